// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic stage registers of the pipelined core.
// Holds the occupancy encoding and the default payload width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } skid_state_t;

  localparam int PIPE_WIDTH = 32;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register: main slot drives the output, skid slot
// absorbs one word on a downstream stall so that in_ready comes straight from a flop.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      r_state;
  skid_state_t      w_nextState;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_inReady;
  logic             r_outValid;
  logic             w_accept;
  logic             w_drain;
  logic             w_loadMainIn;
  logic             w_loadMainSkid;
  logic             w_loadSkid;

  assign w_accept = in_valid && r_inReady;
  assign w_drain  = r_outValid && out_ready;

  // A flush discards whatever is accepted this edge, so no data slot loads.
  always_comb begin
    w_nextState    = r_state;
    w_loadMainIn   = 1'b0;
    w_loadMainSkid = 1'b0;
    w_loadSkid     = 1'b0;
    if (flush) begin
      w_nextState = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_loadMainIn = 1'b1;
            w_nextState  = ONE;
          end
        end
        ONE: begin
          if (w_accept && w_drain) begin
            w_loadMainIn = 1'b1;
          end else if (w_accept) begin
            w_loadSkid  = 1'b1;
            w_nextState = TWO;
          end else if (w_drain) begin
            w_nextState = EMPTY;
          end
        end
        TWO: begin
          if (w_drain) begin
            w_loadMainSkid = 1'b1;
            w_nextState    = ONE;
          end
        end
        default: w_nextState = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_inReady  <= (w_nextState != TWO);
      r_outValid <= (w_nextState != EMPTY);
      if (w_loadMainIn) begin
        r_main <= in_data;
      end else if (w_loadMainSkid) begin
        r_main <= r_skid;
      end
      if (w_loadSkid) begin
        r_skid <= in_data;
      end
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_data  = r_main;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: a queue of accepted words models the
// two-entry FIFO, and every cycle the DUT outputs are compared against it.
module tb_pipe_skid_reg;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  logic [W-1:0] expQueue[$];
  bit           modelKnown;
  bit           afterReset;
  int           checkCount;
  int           errorCount;

  pipe_skid_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare outputs against the model, then advance
  // the model by the handshakes the specification says happen at the edge.
  task automatic applyStimulus(input logic rstV, input logic fl, input logic vld,
                               input logic [W-1:0] data, input logic ordy);
    bit acc;
    bit drn;
    rst = rstV; flush = fl; in_valid = vld; in_data = data; out_ready = ordy;
    if (modelKnown) begin
      checkOutput("outValid", W'(out_valid), W'(expQueue.size() != 0));
      checkOutput("inReady", W'(in_ready), W'(expQueue.size() < 2));
      if (expQueue.size() != 0)
        checkOutput("outData", out_data, expQueue[0]);
      else if (afterReset)
        checkOutput("outDataReset", out_data, '0);
    end
    acc = vld && (expQueue.size() < 2);
    drn = ordy && (expQueue.size() != 0);
    @(posedge clk);
    #1;
    if (rstV) begin
      expQueue.delete();
      modelKnown = 1'b1;
      afterReset = 1'b1;
    end else if (fl) begin
      expQueue.delete();
    end else begin
      if (drn) void'(expQueue.pop_front());
      if (acc) begin
        expQueue.push_back(data);
        afterReset = 1'b0;
      end
    end
  endtask

  initial begin
    bit drained;
    checkCount = 0;
    errorCount = 0;
    modelKnown = 1'b0;
    afterReset = 1'b0;

    // Reset and idle
    applyStimulus(1, 0, 0, '0, 0);
    applyStimulus(1, 0, 0, '0, 0);
    applyStimulus(0, 0, 0, '0, 1);
    applyStimulus(0, 0, 0, '0, 1);

    // Full-throughput stream
    applyStimulus(0, 0, 1, 32'h11, 1);
    applyStimulus(0, 0, 1, 32'h22, 1);
    applyStimulus(0, 0, 1, 32'h33, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, '0, 1);

    // Stall fills both slots, then recovery keeps order
    applyStimulus(0, 0, 1, 32'hA1, 0);
    applyStimulus(0, 0, 1, 32'hA2, 0);
    applyStimulus(0, 0, 1, 32'hA3, 0);
    applyStimulus(0, 0, 1, 32'hA3, 0);
    applyStimulus(0, 0, 1, 32'hA3, 1);
    applyStimulus(0, 0, 1, 32'hA3, 1);
    applyStimulus(0, 0, 0, '0, 1);
    applyStimulus(0, 0, 0, '0, 1);

    // Flush from TWO squashes held words and the word offered on the flush edge
    applyStimulus(0, 0, 1, 32'hB1, 0);
    applyStimulus(0, 0, 1, 32'hB2, 0);
    applyStimulus(0, 1, 1, 32'hB3, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, '0, 1);

    // Simultaneous accept and drain in ONE
    applyStimulus(0, 0, 1, 32'hC1, 0);
    applyStimulus(0, 0, 1, 32'hC2, 1);
    applyStimulus(0, 0, 0, '0, 1);
    applyStimulus(0, 0, 0, '0, 1);

    // Reset beats flush while holding two words
    applyStimulus(0, 0, 1, 32'hE1, 0);
    applyStimulus(0, 0, 1, 32'hE2, 0);
    applyStimulus(1, 1, 1, 32'hEE, 0);
    applyStimulus(0, 0, 1, 32'hD1, 0);
    applyStimulus(0, 0, 0, '0, 1);
    applyStimulus(0, 0, 0, '0, 1);

    // Random traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, ($urandom_range(0, 15) == 0), $urandom_range(0, 1), $urandom,
                    ($urandom_range(0, 3) != 0));
    end

    // Bounded final drain
    drained = 1'b0;
    for (int i = 0; i < 10 && !drained; i++) begin
      applyStimulus(0, 0, 0, '0, 1);
      drained = (expQueue.size() == 0);
    end
    checkOutput("drainDone", W'(drained), W'(1));
    applyStimulus(0, 0, 0, '0, 1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
